my_regfile_wr: RTL and testbench

Write-side companion to the 16×16 register-file read port. Owns the register array, loads every register with its own index (rf[i] = i) through a post-reset init sequence, and accepts write requests over a valid/ready handshake into a small write queue that drains one entry per cycle into the array. Keeps a combinational read port so existing readers of rd1 see the same contents.

---
 rtl/my_regfile_pkg.sv | 18 +
 rtl/my_regfile_wq.sv | 50 +++++
 rtl/my_regfile_wr.sv | 100 ++++++++++
 tb/tb_my_regfile_wr.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/my_regfile_pkg.sv
// Shared types for the register-file write side: default widths, control states
// and the queued write entry.
package my_regfile_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [AW_DEF-1:0] idx;
        logic [DW_DEF-1:0] data;
    } wentry_t;

endpackage

// File: rtl/my_regfile_wq.sv
// Write queue: synchronous FIFO of packed write entries with occupancy count
// and a synchronous flush on rst. Storage itself is never reset.
module my_regfile_wq #(
    parameter int EW    = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [EW-1:0]            din,
    input  logic                     pop,
    output logic [EW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/my_regfile_wr.sv
// Register-file write side: owns the array, self-loads rf[i] = i after reset,
// then drains queued write requests one per cycle. rd1 is a combinational read.
module my_regfile_wr
    import my_regfile_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wvalid,
    output logic          wready,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] n1,
    output logic [DW-1:0] rd1,
    output logic          busy
);

    localparam int NREG = 2**AW;
    localparam int CW   = $clog2(QDEPTH) + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] rf [NREG];

    wentry_t       push_e, head_e;
    logic          push, pop, full, empty;
    logic [CW-1:0] count;

    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wdat;

    assign push_e.idx  = wn;
    assign push_e.data = wd;

    my_regfile_wq #(
        .EW    ($bits(wentry_t)),
        .DEPTH (QDEPTH)
    ) u_wq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_e),
        .pop   (pop),
        .dout  (head_e),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // INIT and drain share the single array write port, selected by state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        pop     = 1'b0;
        wa      = ptr_q;
        wdat    = {{(DW-AW){1'b0}}, ptr_q};
        if (!rst) begin
            case (state_q)
                INIT: begin
                    we    = 1'b1;
                    ptr_d = ptr_q + AW'(1);
                    if (&ptr_q) state_d = RUN;
                end
                RUN: begin
                    pop  = !empty;
                    we   = !empty;
                    wa   = head_e.idx;
                    wdat = head_e.data;
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) rf[wa] <= wdat;
    end

    // Full blocks acceptance even when a pop happens in the same cycle
    assign wready = !rst && (state_q == RUN) && !full;
    assign push   = wvalid && wready;
    assign busy   = rst || (state_q == INIT) || (count != '0);
    assign rd1    = rf[n1];

endmodule

// File: tb/tb_my_regfile_wr.sv
// Directed + randomized bench for my_regfile_wr against a queue/array reference model.
module tb_my_regfile_wr;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wvalid;
    logic          wready;
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
    logic [AW-1:0] n1;
    logic [DW-1:0] rd1;
    logic          busy;

    int checks = 0;
    int errors = 0;

    my_regfile_wr #(.DW(DW), .AW(AW), .QDEPTH(QD)) dut (
        .clk    (clk),
        .rst    (rst),
        .wvalid (wvalid),
        .wready (wready),
        .wn     (wn),
        .wd     (wd),
        .n1     (n1),
        .rd1    (rd1),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: spec-level view of array, init progress and pending writes
    logic [DW-1:0] mrf [16];
    bit            mrun;
    int            mptr;
    logic [AW+DW-1:0] pend [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_wready();
        return !rst && mrun && (pend.size() < QD);
    endfunction

    // One clock: check combinational outputs, take the edge, advance the model
    task automatic cyc();
        bit acc;
        #1;
        chk("wready", 32'(wready), 32'(exp_wready()));
        chk("busy", 32'(busy), 32'(rst || !mrun || pend.size() != 0));
        if (!$isunknown(mrf[n1])) chk("rd1", 32'(rd1), 32'(mrf[n1]));
        acc = wvalid && exp_wready();
        @(posedge clk);
        if (rst) begin
            mrun = 0;
            mptr = 0;
            pend.delete();
        end else if (!mrun) begin
            mrf[mptr] = DW'(mptr);
            mptr++;
            if (mptr == 16) mrun = 1;
        end else begin
            if (pend.size() != 0) begin
                logic [AW+DW-1:0] e;
                e = pend.pop_front();
                mrf[e[AW+DW-1:DW]] = e[DW-1:0];
            end
            if (acc) pend.push_back({wn, wd});
        end
        #1;
    endtask

    task automatic read_all();
        wvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n1 = AW'(i);
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mrf[i] = 'x;
        mrun = 0; mptr = 0;
        rst = 1'b1; wvalid = 1'b0; wn = '0; wd = '0; n1 = '0;
        repeat (3) cyc();

        // INIT with a write request held high: must be ignored
        rst = 1'b0; wvalid = 1'b1; wn = 4'd7; wd = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            n1 = AW'($urandom_range(15));
            cyc();
        end
        wvalid = 1'b0;
        #1;
        chk("wready_after_init", 32'(wready), 32'd1);
        chk("busy_after_init", 32'(busy), 32'd0);
        read_all();
        n1 = 4'd7; #1;
        chk("rf7_init", 32'(rd1), 32'd7);

        // Single write then read back
        wvalid = 1'b1; wn = 4'd3; wd = 16'hABCD; n1 = 4'd3;
        cyc();
        wvalid = 1'b0;
        cyc();
        chk("rf3_written", 32'(rd1), 32'hABCD);
        cyc();
        read_all();

        // Back-to-back writes to the same index
        for (int v = 1; v <= 3; v++) begin
            wvalid = 1'b1; wn = 4'd5; wd = DW'(v); n1 = 4'd5;
            cyc();
        end
        wvalid = 1'b0;
        cyc(); cyc();
        chk("rf5_last_wins", 32'(rd1), 32'd3);

        // Five consecutive requests to distinct indices
        for (int i = 0; i < 5; i++) begin
            wvalid = 1'b1; wn = AW'(8 + i); wd = DW'($urandom);
            n1 = AW'(8 + i);
            cyc();
        end
        wvalid = 1'b0;
        read_all();

        // Reset with a write in flight, then full reload
        wvalid = 1'b1; wn = 4'd9; wd = 16'hBEEF; n1 = 4'd9;
        cyc();
        wvalid = 1'b0; rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        // Reset again partway through INIT
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (16) cyc();
        read_all();
        n1 = 4'd9; #1;
        chk("rf9_reloaded", 32'(rd1), 32'd9);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(99) < 2);
            wvalid = $urandom_range(1);
            wn     = AW'($urandom);
            wd     = DW'($urandom);
            n1     = AW'($urandom);
            cyc();
        end
        rst = 1'b0; wvalid = 1'b0;
        repeat (20) cyc();
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
